conv_layer_sequencer: RTL

Control sequencer for the convolutional layer datapath. On `start` it walks every output pixel, filter, input channel and kernel tap, and issues one MAC tap per accepted handshake. Each tap carries input-feature-map and weight addresses, a zero-padding flag, and accumulator first/last markers. It sits between the layer-level controller (start/done) and the MAC/accumulator datapath with its IFM and weight memories. It replaces the unrolled loop nest with a one-tap-per-cycle schedule.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_layer_sequencer_wrap_counter.sv | 25 ++
 rtl/conv_layer_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution-layer tap sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_IMG_W    = 256;
  localparam int DEF_IMG_H    = 256;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_FILTERS  = 64;
  localparam int DEF_K        = 3;
  localparam int DEF_PAD      = 1;

  localparam int DEF_IFM_AW  = $clog2(DEF_IMG_W * DEF_IMG_H * DEF_CHANNELS);
  localparam int DEF_WGT_AW  = $clog2(DEF_FILTERS * DEF_CHANNELS * DEF_K * DEF_K);
  localparam int DEF_BIAS_AW = $clog2(DEF_FILTERS);

  localparam int DEF_TAPS_PER_OUT = DEF_CHANNELS * DEF_K * DEF_K;

  // Width of a counter over n values; a degenerate one-value loop still needs a bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_wrap_counter.sv
// Modulo-MAX counter with a combinational carry, chained to form the loop nest.
module wrap_counter
  import conv_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [cw(MAX)-1:0] count,
  output logic              wrap
);

  localparam int W = cw(MAX);

  assign wrap = en && (count == W'(MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Walks y/x/f/c/ky/kx and issues one registered MAC tap per accepted handshake.
module conv_layer_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int FILTERS  = DEF_FILTERS,
  parameter int K        = DEF_K,
  parameter int PAD      = DEF_PAD
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   tap_valid,
  input  logic                                   tap_ready,
  output logic                                   tap_first,
  output logic                                   tap_last,
  output logic                                   pad_zero,
  output logic [cw(IMG_W*IMG_H*CHANNELS)-1:0]    ifm_addr,
  output logic [cw(FILTERS*CHANNELS*K*K)-1:0]    wgt_addr,
  output logic [cw(FILTERS)-1:0]                 bias_addr,
  output logic [cw(IMG_H)-1:0]                   out_y,
  output logic [cw(IMG_W)-1:0]                   out_x,
  output logic [cw(FILTERS)-1:0]                 out_f
);

  localparam int IFM_AW = cw(IMG_W * IMG_H * CHANNELS);
  localparam int WGT_AW = cw(FILTERS * CHANNELS * K * K);
  localparam int YW     = cw(IMG_H);
  localparam int XW     = cw(IMG_W);
  localparam int FW     = cw(FILTERS);
  localparam int CHW    = cw(CHANNELS);
  localparam int KW     = cw(K);

  state_t state, state_nxt;

  logic           start_acc, hs;
  logic           kx_wrap, ky_wrap, c_wrap, f_wrap, x_wrap, y_wrap;
  logic [KW-1:0]  kx_cnt, ky_cnt;
  logic [CHW-1:0] c_cnt;
  logic [FW-1:0]  f_cnt;
  logic [XW-1:0]  x_cnt;
  logic [YW-1:0]  y_cnt;

  assign start_acc = (state == IDLE) && start;
  assign hs        = tap_valid && tap_ready;

  wrap_counter #(.MAX(K))        u_kx (.clk(clk), .rst(rst), .en(hs),      .clr(start_acc), .count(kx_cnt), .wrap(kx_wrap));
  wrap_counter #(.MAX(K))        u_ky (.clk(clk), .rst(rst), .en(kx_wrap), .clr(start_acc), .count(ky_cnt), .wrap(ky_wrap));
  wrap_counter #(.MAX(CHANNELS)) u_c  (.clk(clk), .rst(rst), .en(ky_wrap), .clr(start_acc), .count(c_cnt),  .wrap(c_wrap));
  wrap_counter #(.MAX(FILTERS))  u_f  (.clk(clk), .rst(rst), .en(c_wrap),  .clr(start_acc), .count(f_cnt),  .wrap(f_wrap));
  wrap_counter #(.MAX(IMG_W))    u_x  (.clk(clk), .rst(rst), .en(f_wrap),  .clr(start_acc), .count(x_cnt),  .wrap(x_wrap));
  wrap_counter #(.MAX(IMG_H))    u_y  (.clk(clk), .rst(rst), .en(x_wrap),  .clr(start_acc), .count(y_cnt),  .wrap(y_wrap));

  // The counters already hold the current tap, so these are register outputs.
  assign out_y     = y_cnt;
  assign out_x     = x_cnt;
  assign out_f     = f_cnt;
  assign bias_addr = f_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = RUN;
      RUN:     if (y_wrap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  function automatic int step(input int cnt, input logic en, input logic wrap, input logic clr);
    if (clr || wrap) return 0;
    if (en)          return cnt + 1;
    return cnt;
  endfunction

  // Tap fields are computed from the counters' next values so they register in step with them.
  int   ny, nx, nf, nc, nky, nkx, iy, ix, ifm_nxt, wgt_nxt;
  logic pz_nxt, run_nxt;

  always_comb begin
    ny      = step(int'(y_cnt),  x_wrap,  y_wrap,  start_acc);
    nx      = step(int'(x_cnt),  f_wrap,  x_wrap,  start_acc);
    nf      = step(int'(f_cnt),  c_wrap,  f_wrap,  start_acc);
    nc      = step(int'(c_cnt),  ky_wrap, c_wrap,  start_acc);
    nky     = step(int'(ky_cnt), kx_wrap, ky_wrap, start_acc);
    nkx     = step(int'(kx_cnt), hs,      kx_wrap, start_acc);
    iy      = ny + nky - PAD;
    ix      = nx + nkx - PAD;
    pz_nxt  = (iy < 0) || (iy >= IMG_H) || (ix < 0) || (ix >= IMG_W);
    ifm_nxt = pz_nxt ? 0 : ((iy * IMG_W) + ix) * CHANNELS + nc;
    wgt_nxt = ((nf * CHANNELS + nc) * K + nky) * K + nkx;
    run_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      tap_valid <= 1'b0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
      pad_zero  <= 1'b0;
      ifm_addr  <= '0;
      wgt_addr  <= '0;
    end else begin
      busy      <= run_nxt;
      done      <= (state_nxt == DONE);
      tap_valid <= run_nxt;
      tap_first <= run_nxt && (nc == 0) && (nky == 0) && (nkx == 0);
      tap_last  <= run_nxt && (nc == CHANNELS - 1) && (nky == K - 1) && (nkx == K - 1);
      pad_zero  <= run_nxt && pz_nxt;
      ifm_addr  <= IFM_AW'(run_nxt ? ifm_nxt : 0);
      wgt_addr  <= WGT_AW'(wgt_nxt);
    end
  end

endmodule
